// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the CPU data port and a
// DMA (loader/debug) port.
//
// The CPU normally wins. A DMA request that keeps losing accumulates a wait
// count, and once that count reaches DMA_WAIT_MAX the DMA takes the next cycle.
// Grants and the RAM-side mux are combinational. Read data comes back one
// cycle after the grant and is steered using the registered owner state.
//
// Optional feature (macro MEM_ARB_STATS_EN): two saturating 16-bit counters,
// one for CPU stall cycles and one for DMA grants.
//
// Ports
//   clk, rst              clock; synchronous active-low reset
//   cpu_req/we/addr/wdata CPU request side
//   cpu_gnt, cpu_stall    CPU accepted this cycle / CPU held off
//   cpu_rvalid, cpu_rdata CPU read response (one cycle after grant)
//   dma_req/we/addr/wdata DMA request side
//   dma_gnt               DMA accepted this cycle
//   dma_rvalid, dma_rdata DMA read response (one cycle after grant)
//   mem_en/we/addr/wdata  RAM request, zero when nothing is granted
//   mem_rdata             RAM read data, valid one cycle after a read enable
//   stat_cpu_stall_cnt    (MEM_ARB_STATS_EN) cycles with cpu_stall high
//   stat_dma_gnt_cnt      (MEM_ARB_STATS_EN) cycles with dma_gnt high
//
// Owner FSM
//   state  | meaning
//   IDLE   | no read outstanding; no response this cycle
//   RD_CPU | CPU read granted last cycle; mem_rdata belongs to the CPU
//   RD_DMA | DMA read granted last cycle; mem_rdata belongs to the DMA
module mem_arbiter #(
  parameter int unsigned DMA_WAIT_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [14:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [15:0] dma_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_cpu_stall_cnt,
  output logic [15:0] stat_dma_gnt_cnt
`endif
);

  localparam logic [3:0] WAIT_MAX = 4'(DMA_WAIT_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_CPU = 2'd1,
    RD_DMA = 2'd2
  } owner_t;

  owner_t     owner;
  logic [3:0] wait_cnt;
  logic       starved;

  always_comb begin
    starved    = dma_req & (wait_cnt >= WAIT_MAX);
    cpu_gnt    = 1'b0;
    dma_gnt    = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    // Nothing is granted while reset is held.
    if (rst) begin
      if (cpu_req && !starved) begin
        cpu_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
      end
    end

    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end

    // Owner is only cleared at a reset edge, so also gate on rst. This keeps a
    // read granted just before reset from leaking out during reset.
    cpu_rvalid = rst & (owner == RD_CPU);
    dma_rvalid = rst & (owner == RD_DMA);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dma_rdata  = dma_rvalid ? mem_rdata : '0;
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner    <= IDLE;
      wait_cnt <= '0;
    end else begin
      if (cpu_gnt && !cpu_we) begin
        owner <= RD_CPU;
      end else if (dma_gnt && !dma_we) begin
        owner <= RD_DMA;
      end else begin
        owner <= IDLE;
      end

      if (dma_req && !dma_gnt) begin
        if (wait_cnt != 4'hF) begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_cpu_stall_cnt <= '0;
      stat_dma_gnt_cnt   <= '0;
    end else begin
      if (cpu_stall && (stat_cpu_stall_cnt != 16'hFFFF)) begin
        stat_cpu_stall_cnt <= stat_cpu_stall_cnt + 16'd1;
      end
      if (dma_gnt && (stat_dma_gnt_cnt != 16'hFFFF)) begin
        stat_dma_gnt_cnt <= stat_dma_gnt_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. A behavioural RAM answers the DMA/CPU reads. A
// per-cycle reference model derived from the arbitration rules is compared
// with every output on each falling edge. Directed sequences add literal
// expectations taken from the worked examples.
module tb_mem_arbiter;

  localparam int WAIT_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [14:0] dma_addr = '0;
  logic [15:0] dma_wdata = '0;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [15:0] cpu_rdata, dma_rdata;
  logic        mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_cpu_stall_cnt, stat_dma_gnt_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] ram [0:32767];

  always #5 clk = ~clk;

  mem_arbiter #(.DMA_WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .stat_cpu_stall_cnt(stat_cpu_stall_cnt), .stat_dma_gnt_cnt(stat_dma_gnt_cnt)
`endif
  );

  // Synchronous RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_wait  = 0;   // consecutive denied DMA cycles
  int          m_pend  = 0;   // 0 none, 1 CPU read outstanding, 2 DMA read outstanding
  logic [14:0] m_paddr = '0;
  int          m_stall_cnt = 0;
  int          m_dgnt_cnt  = 0;

  always @(negedge clk) begin
    bit          e_cpu, e_dma, e_stall, e_crv, e_drv;
    bit          e_en, e_we;
    logic [14:0] e_addr;
    logic [15:0] e_wdata, e_crd, e_drd;
    e_cpu = rst && cpu_req && !(dma_req && m_wait >= WAIT_MAX);
    e_dma = rst && dma_req && !e_cpu;
    e_stall = cpu_req && !e_cpu;
    e_en    = e_cpu || e_dma;
    e_we    = e_cpu ? cpu_we : (e_dma ? dma_we : 1'b0);
    e_addr  = e_cpu ? cpu_addr : (e_dma ? dma_addr : 15'd0);
    e_wdata = e_cpu ? cpu_wdata : (e_dma ? dma_wdata : 16'd0);
    e_crv   = rst && m_pend == 1;
    e_drv   = rst && m_pend == 2;
    e_crd   = e_crv ? ram[m_paddr] : 16'd0;
    e_drd   = e_drv ? ram[m_paddr] : 16'd0;

    check("m_cpu_gnt", 32'(cpu_gnt), 32'(e_cpu));
    check("m_dma_gnt", 32'(dma_gnt), 32'(e_dma));
    check("m_cpu_stall", 32'(cpu_stall), 32'(e_stall));
    check("m_mem_en", 32'(mem_en), 32'(e_en));
    check("m_mem_we", 32'(mem_we), 32'(e_we));
    check("m_mem_addr", 32'(mem_addr), 32'(e_addr));
    check("m_mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    check("m_cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
    check("m_cpu_rdata", 32'(cpu_rdata), 32'(e_crd));
    check("m_dma_rvalid", 32'(dma_rvalid), 32'(e_drv));
    check("m_dma_rdata", 32'(dma_rdata), 32'(e_drd));
`ifdef MEM_ARB_STATS_EN
    check("m_stat_stall", 32'(stat_cpu_stall_cnt), 32'(m_stall_cnt));
    check("m_stat_dgnt", 32'(stat_dma_gnt_cnt), 32'(m_dgnt_cnt));
`endif

    // state for the next cycle (inputs are stable until after the next rising edge)
    if (!rst) begin
      m_wait = 0; m_pend = 0; m_stall_cnt = 0; m_dgnt_cnt = 0;
    end else begin
      m_wait = (dma_req && !e_dma) ? ((m_wait < 15) ? m_wait + 1 : 15) : 0;
      if (e_cpu && !cpu_we) begin m_pend = 1; m_paddr = cpu_addr; end
      else if (e_dma && !dma_we) begin m_pend = 2; m_paddr = dma_addr; end
      else m_pend = 0;
      if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
      if (e_dma && m_dgnt_cnt < 65535) m_dgnt_cnt++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  typedef struct packed {
    logic        creq, cwe;
    logic [14:0] caddr;
    logic [15:0] cwd;
    logic        dreq, dwe;
    logic [14:0] daddr;
    logic [15:0] dwd;
  } vec_t;

  bit exp_dma_pat [10];
  vec_t vecs [10];

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 16'(i * 3 + 1);
    ram[15'h4082] = 16'd27654;
    ram[15'h0005] = 16'h1111;
    ram[15'h0006] = 16'h2222;
    exp_dma_pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    // Reset held two cycles with both requesting.
    rst = 0; cpu_req = 1; dma_req = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_cpu_gnt", 32'(cpu_gnt), 0);
      check("rst_dma_gnt", 32'(dma_gnt), 0);
      check("rst_mem_en", 32'(mem_en), 0);
      tick();
    end

    // Release with both still requesting: contention pattern from cycle 0.
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("cont_cpu_gnt", 32'(cpu_gnt), 32'(!exp_dma_pat[i]));
      check("cont_dma_gnt", 32'(dma_gnt), 32'(exp_dma_pat[i]));
      check("cont_cpu_stall", 32'(cpu_stall), 32'(exp_dma_pat[i]));
      tick();
    end
    idle_inputs();
`ifdef MEM_ARB_STATS_EN
    @(negedge clk);
    check("stat_stall_10", 32'(stat_cpu_stall_cnt), 2);
    check("stat_dgnt_10", 32'(stat_dma_gnt_cnt), 2);
`endif
    tick();

    // CPU read.
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h4082;
    @(negedge clk);
    check("rd_cpu_gnt", 32'(cpu_gnt), 1);
    check("rd_mem_addr", 32'(mem_addr), 32'h4082);
    tick();
    idle_inputs();
    @(negedge clk);
    check("rd_cpu_rvalid", 32'(cpu_rvalid), 1);
    check("rd_cpu_rdata", 32'(cpu_rdata), 27654);
    check("rd_dma_rvalid", 32'(dma_rvalid), 0);
    tick();

    // DMA write at the top address.
    dma_req = 1; dma_we = 1; dma_addr = 15'h7FFF; dma_wdata = 16'd350;
    @(negedge clk);
    check("wr_dma_gnt", 32'(dma_gnt), 1);
    check("wr_mem_we", 32'(mem_we), 1);
    check("wr_mem_addr", 32'(mem_addr), 32'h7FFF);
    check("wr_mem_wdata", 32'(mem_wdata), 350);
    tick();
    idle_inputs();
    @(negedge clk);
    check("wr_no_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("wr_no_dma_rvalid", 32'(dma_rvalid), 0);
    check("wr_ram", 32'(ram[15'h7FFF]), 350);
    tick();

    // Alternating back-to-back reads: CPU then DMA.
    cpu_req = 1; cpu_addr = 15'h0005;
    tick();
    cpu_req = 0; dma_req = 1; dma_we = 0; dma_addr = 15'h0006;
    @(negedge clk);
    check("alt_dma_gnt", 32'(dma_gnt), 1);
    check("alt_cpu_rdata", 32'(cpu_rdata), 32'h1111);
    check("alt_dma_rvalid0", 32'(dma_rvalid), 0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("alt_dma_rdata", 32'(dma_rdata), 32'h2222);
    check("alt_cpu_rvalid1", 32'(cpu_rvalid), 0);
    tick();

    // CPU read granted, then reset asserted for the following edges.
    cpu_req = 1; cpu_addr = 15'h4082;
    tick();
    idle_inputs();
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rstrd_cpu_rvalid", 32'(cpu_rvalid), 0);
      check("rstrd_cpu_rdata", 32'(cpu_rdata), 0);
      tick();
    end
    rst = 1;
    @(negedge clk);
    check("rstrd_after_rvalid", 32'(cpu_rvalid), 0);
    tick();

    // Mixed directed vectors, checked by the model.
    vecs[0] = '{1, 1, 15'h0100, 16'hBEEF, 0, 0, 15'h0, 16'h0};
    vecs[1] = '{1, 0, 15'h0100, 16'h0, 1, 0, 15'h0006, 16'h0};
    vecs[2] = '{0, 0, 15'h0, 16'h0, 1, 0, 15'h0006, 16'h0};
    vecs[3] = '{1, 0, 15'h0005, 16'h0, 1, 1, 15'h0200, 16'h1234};
    vecs[4] = '{1, 0, 15'h0200, 16'h0, 1, 1, 15'h0201, 16'h5678};
    vecs[5] = '{1, 1, 15'h0202, 16'hAAAA, 1, 0, 15'h0201, 16'h0};
    vecs[6] = '{1, 0, 15'h0202, 16'h0, 1, 0, 15'h0100, 16'h0};
    vecs[7] = '{1, 0, 15'h0201, 16'h0, 1, 0, 15'h0100, 16'h0};
    vecs[8] = '{0, 0, 15'h0, 16'h0, 0, 0, 15'h0, 16'h0};
    vecs[9] = '{0, 0, 15'h0, 16'h0, 0, 0, 15'h0, 16'h0};
    for (int i = 0; i < 10; i++) begin
      {cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata} = vecs[i];
      tick();
    end
    idle_inputs();
    tick();

`ifdef MEM_ARB_STATS_EN
    // Drive the DMA grant counter into saturation.
    rst = 0; tick(); rst = 1;
    dma_req = 1; dma_we = 1; dma_addr = 15'h0300;
    repeat (65540) @(posedge clk);
    #1;
    @(negedge clk);
    check("stat_dgnt_sat", 32'(stat_dma_gnt_cnt), 32'hFFFF);
    check("stat_stall_zero", 32'(stat_cpu_stall_cnt), 0);
    tick();
    idle_inputs();
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
